mem_bus_stage: RTL and testbench

MEM_BUS_STAGE -- requirements
Module: mem_bus_stage

---
 rtl/mem_bus_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_bus_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: forwards ALU results to write-back, or runs one data-bus
// access per memory op (IDLE -> BUSY -> IDLE), stalling upstream until ack.
// Big-endian byte lanes; stores replicate data across lanes, loads extract and extend.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses
// (excp_align pulse, no bus request) instead of silently aligning the address down.
module mem_bus_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        excp_align
);

  localparam logic [7:0] OpLb  = 8'hE0;
  localparam logic [7:0] OpLbu = 8'hE4;
  localparam logic [7:0] OpLh  = 8'hE1;
  localparam logic [7:0] OpLhu = 8'hE5;
  localparam logic [7:0] OpLw  = 8'hE3;
  localparam logic [7:0] OpSb  = 8'hE8;
  localparam logic [7:0] OpSh  = 8'hE9;
  localparam logic [7:0] OpSw  = 8'hEB;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      r_state;
  logic        r_is_load;
  logic        r_byte;
  logic        r_half;
  logic        r_sign;
  logic [1:0]  r_off;
  logic [4:0]  r_wd;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic        w_sign;
  logic        w_misalign;
  logic [1:0]  w_off;
  logic [3:0]  w_sel;
  logic [31:0] w_store_data;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_data;

  // Decode the incoming op into access size, direction and lane selection.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_byte     = 1'b0;
    w_half     = 1'b0;
    w_word     = 1'b0;
    w_sign     = 1'b0;
    case (mem_aluop)
      OpLb:    begin w_is_load  = 1'b1; w_byte = 1'b1; w_sign = 1'b1; end
      OpLbu:   begin w_is_load  = 1'b1; w_byte = 1'b1; end
      OpLh:    begin w_is_load  = 1'b1; w_half = 1'b1; w_sign = 1'b1; end
      OpLhu:   begin w_is_load  = 1'b1; w_half = 1'b1; end
      OpLw:    begin w_is_load  = 1'b1; w_word = 1'b1; end
      OpSb:    begin w_is_store = 1'b1; w_byte = 1'b1; end
      OpSh:    begin w_is_store = 1'b1; w_half = 1'b1; end
      OpSw:    begin w_is_store = 1'b1; w_word = 1'b1; end
      default: ;
    endcase

    // Sub-word offset with the bits below the access size forced to zero.
    if (w_byte)      w_off = mem_addr[1:0];
    else if (w_half) w_off = {mem_addr[1], 1'b0};
    else             w_off = 2'b00;

    if (w_byte)      w_sel = 4'b1000 >> w_off;
    else if (w_half) w_sel = w_off[1] ? 4'b0011 : 4'b1100;
    else if (w_word) w_sel = 4'b1111;
    else             w_sel = 4'b0000;

    if (w_byte)      w_store_data = {4{mem_reg2[7:0]}};
    else if (w_half) w_store_data = {2{mem_reg2[15:0]}};
    else             w_store_data = mem_reg2;

`ifdef MEM_ALIGN_CHECK_EN
    w_misalign = (w_half & mem_addr[0]) | (w_word & (mem_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  // Extract and extend the returned lane using the attributes latched at issue.
  always_comb begin
    case (r_off)
      2'd0:    w_lane_byte = dbus_rdata[31:24];
      2'd1:    w_lane_byte = dbus_rdata[23:16];
      2'd2:    w_lane_byte = dbus_rdata[15:8];
      default: w_lane_byte = dbus_rdata[7:0];
    endcase
    w_lane_half = r_off[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
    if (r_byte)      w_load_data = {{24{r_sign & w_lane_byte[7]}}, w_lane_byte};
    else if (r_half) w_load_data = {{16{r_sign & w_lane_half[15]}}, w_lane_half};
    else             w_load_data = dbus_rdata;
  end

  // Stall while an access is being issued or is still awaiting ack; never during reset.
  always_comb begin
    stallreq = 1'b0;
    if (!rst) begin
      if (r_state == StIdle) stallreq = (w_is_load | w_is_store) & ~w_misalign;
      else                   stallreq = ~dbus_ack;
    end
  end

  // Stage FSM: pass-through in IDLE, hold the bus request in BUSY until ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_is_load  <= 1'b0;
      r_byte     <= 1'b0;
      r_half     <= 1'b0;
      r_sign     <= 1'b0;
      r_off      <= 2'b00;
      r_wd       <= 5'd0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_sel   <= 4'd0;
      dbus_wdata <= 32'd0;
      wb_wd      <= 5'd0;
      wb_wreg    <= 1'b0;
      wb_wdata   <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_misalign) begin
            wb_wreg <= 1'b0;
          end else if (w_is_load | w_is_store) begin
            r_state    <= StBusy;
            r_is_load  <= w_is_load;
            r_byte     <= w_byte;
            r_half     <= w_half;
            r_sign     <= w_sign;
            r_off      <= w_off;
            r_wd       <= mem_wd;
            dbus_req   <= 1'b1;
            dbus_we    <= w_is_store;
            dbus_addr  <= {mem_addr[31:2], 2'b00};
            dbus_sel   <= w_sel;
            dbus_wdata <= w_store_data;
            wb_wreg    <= 1'b0;
          end else begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
          end
        end
        StBusy: begin
          wb_wreg <= 1'b0;
          if (dbus_ack) begin
            r_state  <= StIdle;
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            if (r_is_load) begin
              wb_wreg  <= 1'b1;
              wb_wd    <= r_wd;
              wb_wdata <= w_load_data;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_excp_align;

  // One-cycle flag for a trapped misaligned access seen in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_excp_align <= 1'b0;
    else     r_excp_align <= (r_state == StIdle) & w_misalign;
  end

  assign excp_align = r_excp_align;
`else
  assign excp_align = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_stage.sv
// Self-checking bench for mem_bus_stage: literal vector table, hand-written
// corner sequences (ack in IDLE, reset mid-access) and random ops checked
// against a size/offset arithmetic model.
module tb_mem_bus_stage;

  localparam int KNop   = 0;
  localparam int KLoad  = 1;
  localparam int KStore = 2;
  localparam int KExcp  = 3;

  typedef struct {
    int          kind;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          delay;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr;
  logic [31:0] mem_reg2;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        excp_align;

  int n_vec = 0;
  int n_bad = 0;

  mem_bus_stage dut (
    .clk        (clk),
    .rst        (rst),
    .mem_wd     (mem_wd),
    .mem_wreg   (mem_wreg),
    .mem_wdata  (mem_wdata),
    .mem_aluop  (mem_aluop),
    .mem_addr   (mem_addr),
    .mem_reg2   (mem_reg2),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_sel   (dbus_sel),
    .dbus_wdata (dbus_wdata),
    .dbus_rdata (dbus_rdata),
    .dbus_ack   (dbus_ack),
    .wb_wd      (wb_wd),
    .wb_wreg    (wb_wreg),
    .wb_wdata   (wb_wdata),
    .stallreq   (stallreq),
    .excp_align (excp_align)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_nop();
    mem_aluop = 8'h00;
    mem_addr  = 32'd0;
    mem_reg2  = 32'd0;
    mem_wd    = 5'd0;
    mem_wreg  = 1'b0;
    mem_wdata = 32'd0;
  endtask

  function automatic vec_t mk(input int kind, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] rdata, input int delay,
                              input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                              input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                              input logic [31:0] exp_data);
    vec_t v;
    v.kind = kind; v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata;
    v.delay = delay; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
    v.exp_addr = exp_addr; v.exp_sel = exp_sel; v.exp_data = exp_data;
    return v;
  endfunction

  // Reference: derive size/offset from the op, then use shifts and masks.
  function automatic vec_t model(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] reg2, input logic [31:0] rdata,
                                 input int delay, input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata);
    vec_t        v;
    int          size;
    int          off;
    bit          sgn;
    bit          st;
    logic [31:0] mask;
    logic [31:0] field;
    v = mk(KNop, op, addr, reg2, rdata, delay, wd, wreg, wdata, 32'd0, 4'd0, wdata);
    size = 0; sgn = 1'b0; st = 1'b0;
    case (op)
      8'hE0: begin size = 1; sgn = 1'b1; end
      8'hE4: size = 1;
      8'hE1: begin size = 2; sgn = 1'b1; end
      8'hE5: size = 2;
      8'hE3: size = 4;
      8'hE8: begin size = 1; st = 1'b1; end
      8'hE9: begin size = 2; st = 1'b1; end
      8'hEB: begin size = 4; st = 1'b1; end
      default: size = 0;
    endcase
    if (size == 0) return v;
    off = int'(addr[1:0]);
`ifdef MEM_ALIGN_CHECK_EN
    if (off % size != 0) begin
      v.kind = KExcp;
      return v;
    end
`endif
    off = off - (off % size);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v.exp_addr = addr & ~32'd3;
    v.exp_sel = 4'(((1 << size) - 1) << (4 - size - off));
    if (st) begin
      v.kind = KStore;
      v.exp_data = 32'd0;
      for (int k = 0; k < 4 / size; k++) v.exp_data |= (reg2 & mask) << (8 * size * k);
    end else begin
      v.kind = KLoad;
      field = (rdata >> (8 * (4 - size - off))) & mask;
      if (sgn && field[8 * size - 1]) field = field | ~mask;
      v.exp_data = field;
    end
    return v;
  endfunction

  // Apply one op from IDLE and follow it to completion.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    mem_aluop = v.op; mem_addr = v.addr; mem_reg2 = v.reg2;
    mem_wd = v.wd; mem_wreg = v.wreg; mem_wdata = v.wdata;
    dbus_ack = 1'b0; dbus_rdata = $urandom;
    #1;
    if (v.kind == KNop || v.kind == KExcp) begin
      chk("idle_stall", 32'(stallreq), 32'd0);
      @(posedge clk); #1;
      chk("idle_req", 32'(dbus_req), 32'd0);
      if (v.kind == KNop) begin
        chk("pass_wd", 32'(wb_wd), 32'(v.wd));
        chk("pass_wreg", 32'(wb_wreg), 32'(v.wreg));
        chk("pass_wdata", wb_wdata, v.exp_data);
        chk("pass_excp", 32'(excp_align), 32'd0);
      end else begin
        chk("excp_set", 32'(excp_align), 32'd1);
        chk("excp_wreg", 32'(wb_wreg), 32'd0);
        @(negedge clk); set_nop();
        @(posedge clk); #1;
        chk("excp_clear", 32'(excp_align), 32'd0);
      end
      return;
    end
    chk("issue_stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    chk("issue_req", 32'(dbus_req), 32'd1);
    chk("issue_we", 32'(dbus_we), 32'(v.kind == KStore));
    chk("issue_addr", dbus_addr, v.exp_addr);
    chk("issue_sel", 32'(dbus_sel), 32'(v.exp_sel));
    chk("issue_bubble", 32'(wb_wreg), 32'd0);
    if (v.kind == KStore) chk("issue_wdata", dbus_wdata, v.exp_data);
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      mem_aluop = 8'(($urandom_range(0, 7) == 0) ? 8'hE3 : $urandom);
      mem_addr = $urandom; mem_reg2 = $urandom; mem_wd = 5'($urandom);
      mem_wreg = 1'($urandom); mem_wdata = $urandom;
      #1;
      chk("busy_stall", 32'(stallreq), 32'd1);
      @(posedge clk); #1;
      chk("busy_req", 32'(dbus_req), 32'd1);
      chk("busy_addr", dbus_addr, v.exp_addr);
      chk("busy_sel", 32'(dbus_sel), 32'(v.exp_sel));
    end
    @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = v.rdata;
    #1;
    chk("ack_stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    chk("done_req", 32'(dbus_req), 32'd0);
    chk("done_we", 32'(dbus_we), 32'd0);
    chk("done_wreg", 32'(wb_wreg), 32'(v.kind == KLoad));
    if (v.kind == KLoad) begin
      chk("done_wd", 32'(wb_wd), 32'(v.wd));
      chk("done_wdata", wb_wdata, v.exp_data);
    end
    @(negedge clk);
    dbus_ack = 1'b0; set_nop();
  endtask

  vec_t vecs[10];
  vec_t rv;

  initial begin
    vecs[0] = mk(KNop, 8'h21, 32'h0, 32'h0, 32'h0, 0, 5'd3, 1'b1, 32'h1234,
                 32'h0, 4'h0, 32'h1234);
    vecs[1] = mk(KLoad, 8'hE0, 32'h103, 32'h0, 32'h0000_00F0, 3, 5'd7, 1'b0, 32'h0,
                 32'h100, 4'b0001, 32'hFFFF_FFF0);
    vecs[2] = mk(KStore, 8'hE9, 32'h202, 32'hAAAA_BEEF, 32'h0, 0, 5'd9, 1'b1, 32'h0,
                 32'h200, 4'b0011, 32'hBEEF_BEEF);
    vecs[3] = mk(KLoad, 8'hE5, 32'h200, 32'h0, 32'h8001_5A5A, 1, 5'd4, 1'b0, 32'h0,
                 32'h200, 4'b1100, 32'h0000_8001);
`ifdef MEM_ALIGN_CHECK_EN
    vecs[4] = mk(KExcp, 8'hE3, 32'h102, 32'h0, 32'h1234_5678, 0, 5'd5, 1'b1, 32'h77,
                 32'h0, 4'h0, 32'h0);
`else
    vecs[4] = mk(KLoad, 8'hE3, 32'h102, 32'h0, 32'h1234_5678, 0, 5'd5, 1'b1, 32'h77,
                 32'h100, 4'b1111, 32'h1234_5678);
`endif
    vecs[5] = mk(KStore, 8'hE8, 32'h101, 32'h1122_3344, 32'h0, 1, 5'd1, 1'b0, 32'h0,
                 32'h100, 4'b0100, 32'h4444_4444);
    vecs[6] = mk(KLoad, 8'hE1, 32'h206, 32'h0, 32'h0000_8765, 2, 5'd31, 1'b0, 32'h0,
                 32'h204, 4'b0011, 32'hFFFF_8765);
    vecs[7] = mk(KLoad, 8'hE4, 32'h300, 32'h0, 32'h9A00_0000, 0, 5'd12, 1'b0, 32'h0,
                 32'h300, 4'b1000, 32'h0000_009A);
    vecs[8] = mk(KStore, 8'hEB, 32'h40C, 32'hCAFE_F00D, 32'h0, 2, 5'd2, 1'b1, 32'h0,
                 32'h40C, 4'b1111, 32'hCAFE_F00D);
    vecs[9] = mk(KNop, 8'h00, 32'h0, 32'h0, 32'h0, 0, 5'd17, 1'b0, 32'hDEAD_0001,
                 32'h0, 4'h0, 32'hDEAD_0001);

    // Reset with a memory op on the inputs: everything zero, no stall.
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    mem_aluop = 8'hE3; mem_addr = 32'h100; mem_reg2 = 32'h5; mem_wd = 5'd1;
    mem_wreg = 1'b1; mem_wdata = 32'h9;
    @(posedge clk); #1;
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    chk("rst_sel", 32'(dbus_sel), 32'd0);
    chk("rst_wreg", 32'(wb_wreg), 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_excp", 32'(excp_align), 32'd0);
    @(negedge clk); set_nop(); rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Ack while IDLE is ignored; ack already high at issue still yields 2-cycle latency.
    @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    chk("idle_ack_req", 32'(dbus_req), 32'd0);
    @(negedge clk);
    mem_aluop = 8'hE3; mem_addr = 32'h500; mem_wd = 5'd6;
    #1;
    chk("ack_idle_stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    chk("ack_idle_req", 32'(dbus_req), 32'd1);
    chk("ack_idle_wreg", 32'(wb_wreg), 32'd0);
    chk("ack_busy_stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    chk("fast_req", 32'(dbus_req), 32'd0);
    chk("fast_wreg", 32'(wb_wreg), 32'd1);
    chk("fast_wdata", wb_wdata, 32'hFEED_FACE);
    @(negedge clk); dbus_ack = 1'b0; set_nop();

    // Reset mid-BUSY abandons the access; a late ack is ignored.
    @(negedge clk);
    mem_aluop = 8'hE3; mem_addr = 32'h600; mem_wd = 5'd8;
    @(posedge clk); #1;
    chk("mid_req", 32'(dbus_req), 32'd1);
    #2; rst = 1'b1; set_nop(); #1;
    chk("mid_rst_req", 32'(dbus_req), 32'd0);
    chk("mid_rst_stall", 32'(stallreq), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("late_ack_stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    chk("late_ack_req", 32'(dbus_req), 32'd0);
    chk("late_ack_wreg", 32'(wb_wreg), 32'd0);
    chk("late_ack_wdata", wb_wdata, 32'd0);
    @(negedge clk); dbus_ack = 1'b0;

    // Random ops against the model.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] op;
      case ($urandom_range(0, 9))
        0: op = 8'hE0;
        1: op = 8'hE4;
        2: op = 8'hE1;
        3: op = 8'hE5;
        4: op = 8'hE3;
        5: op = 8'hE8;
        6: op = 8'hE9;
        7: op = 8'hEB;
        default: op = 8'($urandom_range(0, 8'hDF));
      endcase
      rv = model(op, $urandom, $urandom, $urandom, $urandom_range(0, 3), 5'($urandom),
                 1'($urandom), $urandom);
      run_op(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
